// File: rtl/topk_top.sv
// Running top-N (N = K = 2**LOG_INPUT_NUM) of all float elements accepted since reset.
// Latency: a vector sampled at edge k is reflected in y after edge k+S+1 (S = bitonic stages).
// Backpressure: none; accepts one vector per cycle, never stalls.
//
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset; clears pipeline valids, loads -inf into T
//   i_valid  x carries a vector to accept this cycle
//   x        packed input vector, lane j at [DATA_WIDTH*(j+1)-1 -: DATA_WIDTH]
//   y        registered accumulator T, same packing, lane 0 = largest
module topk_top #(
  parameter int DATA_WIDTH    = 32,
  parameter int LOG_INPUT_NUM = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] x,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] y
);

  localparam int N = 2**LOG_INPUT_NUM;
  localparam int S = LOG_INPUT_NUM * (LOG_INPUT_NUM + 1) / 2;
  localparam logic [DATA_WIDTH-1:0] NEG_INF = DATA_WIDTH'(32'hFF80_0000);

  // Total-order key: positives get the sign bit set, negatives are inverted, so an
  // unsigned compare of keys orders -NaN < -inf < ... < -0 < +0 < ... < +inf < +NaN.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? ~v : {1'b1, v[DATA_WIDTH-2:0]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (order_key(a) >= order_key(b)) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fmin(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (order_key(a) >= order_key(b)) ? b : a;
  endfunction

  // Stage A: sa_q[0] is the sampled input, sa_q[s] the output of network stage s.
  logic [DATA_WIDTH-1:0] sa_q [0:S][0:N-1];
  logic [DATA_WIDTH-1:0] sa_d [1:S][0:N-1];
  logic [S:0]            vld_q;

  // Stage B accumulator, kept sorted descending.
  logic [DATA_WIDTH-1:0] t_q [0:N-1];
  logic [DATA_WIDTH-1:0] t_d [0:N-1];

  // Bitonic sorting network, descending. Block size 2**(p+1), compare distance 2**q.
  // Within a block whose index bit (p+1) is 0 the lower lane takes the max; blocks
  // with that bit set run ascending so that the next merge sees bitonic input.
  always_comb begin : sort_net
    int   s;
    int   partner;
    logic desc;
    logic lo;
    s       = 1;
    partner = 0;
    desc    = 1'b0;
    lo      = 1'b0;
    for (int a = 1; a <= S; a++) begin
      for (int i = 0; i < N; i++) begin
        sa_d[a][i] = '0;
      end
    end
    for (int p = 0; p < LOG_INPUT_NUM; p++) begin
      for (int q = p; q >= 0; q--) begin
        for (int i = 0; i < N; i++) begin
          partner = i ^ (1 << q);
          desc    = (((i >> (p + 1)) & 1) == 0);
          lo      = (((i >> q) & 1) == 0);
          sa_d[s][i] = (lo == desc) ? fmax(sa_q[s-1][i], sa_q[s-1][partner])
                                    : fmin(sa_q[s-1][i], sa_q[s-1][partner]);
        end
        s = s + 1;
      end
    end
  end

  // Merge: T descending against U reversed (ascending) gives a lane-wise max that is
  // bitonic and holds exactly the top N of the union; half-cleaners then sort it.
  always_comb begin : merge
    logic [DATA_WIDTH-1:0] tmp;
    tmp = '0;
    for (int i = 0; i < N; i++) begin
      t_d[i] = fmax(t_q[i], sa_q[S][N-1-i]);
    end
    for (int q = LOG_INPUT_NUM - 1; q >= 0; q--) begin
      for (int i = 0; i < N; i++) begin
        if (((i >> q) & 1) == 0) begin
          tmp               = t_d[i];
          t_d[i]            = fmax(tmp, t_d[i + (1 << q)]);
          t_d[i + (1 << q)] = fmin(tmp, t_d[i + (1 << q)]);
        end
      end
    end
  end

  // Control state: valid shift chain and accumulator. Reset wins over i_valid, and
  // clearing every valid bit discards all vectors still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++) begin
        t_q[i] <= NEG_INF;
      end
    end else begin
      vld_q <= {vld_q[S-1:0], i_valid};
      if (vld_q[S]) begin
        for (int i = 0; i < N; i++) begin
          t_q[i] <= t_d[i];
        end
      end
    end
  end

  // Datapath registers carry no reset; their contents only matter when the valid is set.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      sa_q[0][j] <= x[DATA_WIDTH*j +: DATA_WIDTH];
    end
    for (int s = 1; s <= S; s++) begin
      for (int j = 0; j < N; j++) begin
        sa_q[s][j] <= sa_d[s][j];
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    assign y[DATA_WIDTH*j +: DATA_WIDTH] = t_q[j];
  end

endmodule

// File: tb/tb_topk_top.sv
// Self-checking bench for topk_top: directed float cases plus randomized traffic
// against a multiset top-16 reference model with an 11-edge delivery delay.
module tb_topk_top;

  localparam int LAT = 11;
  localparam logic [31:0] NINF = 32'hFF80_0000;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic [511:0] x;
  logic [511:0] y;

  int checks;
  int errors;
  int cyc;

  // Reference model: pool holds the current expected top 16 (descending); vectors
  // wait in pend_* until their delivery edge.
  logic [31:0]  pool[$];
  int           pend_due[$];
  logic [511:0] pend_vec[$];

  logic [31:0] one_to_16 [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                  32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                                  32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  topk_top #(.DATA_WIDTH(32), .LOG_INPUT_NUM(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .x       (x),
    .y       (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mkey(input logic [31:0] v);
    return v[31] ? ~v : (v ^ 32'h8000_0000);
  endfunction

  function automatic void pool_reset();
    pool.delete();
    for (int i = 0; i < 16; i++) pool.push_back(NINF);
  endfunction

  function automatic void pool_add(input logic [511:0] v);
    logic [31:0] e;
    int k;
    for (int j = 0; j < 16; j++) pool.push_back(v[32*j +: 32]);
    for (int i = 1; i < pool.size(); i++) begin
      e = pool[i];
      k = i - 1;
      while (k >= 0 && mkey(pool[k]) < mkey(e)) begin
        pool[k+1] = pool[k];
        k--;
      end
      pool[k+1] = e;
    end
    while (pool.size() > 16) void'(pool.pop_back());
  endfunction

  function automatic logic [31:0] small_val(input int n);
    case (n)
      0: return 32'h3F800000;  // 1.0
      1: return 32'hBF800000;  // -1.0
      2: return 32'h00000000;  // +0
      3: return 32'h80000000;  // -0
      4: return 32'h7F800000;  // +inf
      5: return NINF;
      6: return 32'h40000000;  // 2.0
      default: return 32'h3F000000;  // 0.5
    endcase
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 16; j++) begin
      case ($urandom_range(0, 3))
        0: v[32*j +: 32] = $urandom;
        1, 2: v[32*j +: 32] = small_val($urandom_range(0, 7));
        default: v[32*j +: 32] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)),
                                  23'($urandom)};
      endcase
    end
    return v;
  endfunction

  // Advance one rising edge and update the model with what the DUT sampled.
  task automatic tick();
    logic         r;
    logic         v;
    logic [511:0] xv;
    r  = rst;
    v  = i_valid;
    xv = x;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      pend_due.delete();
      pend_vec.delete();
      pool_reset();
    end else if (v) begin
      pend_due.push_back(cyc + LAT);
      pend_vec.push_back(xv);
    end
    while (pend_due.size() > 0 && pend_due[0] == cyc) begin
      pool_add(pend_vec[0]);
      void'(pend_due.pop_front());
      void'(pend_vec.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; x = rand_vec();
    tick();
    rst = 1'b0; i_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (y[32*j +: 32] !== NINF) begin
        errors++;
        $display("FAIL reset_edge lane %0d: got %h expected %h", j, y[32*j +: 32], NINF);
      end
    end
    for (int c = 0; c < 20; c++) begin
      x = rand_vec();
      tick();
    end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (y[32*j +: 32] !== NINF) begin
        errors++;
        $display("FAIL reset_idle lane %0d: got %h expected %h", j, y[32*j +: 32], NINF);
      end
    end
  endtask

  task automatic test_single_and_second();
    int          perm [16];
    int          r;
    int          t;
    logic [31:0] exp2 [16];
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      r = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[r]; perm[r] = t;
    end
    for (int j = 0; j < 16; j++) x[32*j +: 32] = one_to_16[perm[j]];
    i_valid = 1'b1;
    tick();
    for (int j = 0; j < 16; j++) x[32*j +: 32] = 32'hC2C80000;  // -100.0
    x[31:0]   = 32'h42C80000;  // 100.0
    x[63:32]  = 32'hC0A00000;  // -5.0
    x[95:64]  = 32'h41080000;  // 8.5
    x[127:96] = 32'h3F000000;  // 0.5
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      x = rand_vec();
      tick();
    end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (y[32*j +: 32] !== NINF) begin
        errors++;
        $display("FAIL single_early lane %0d: got %h expected %h", j, y[32*j +: 32], NINF);
      end
    end
    tick();
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (y[32*j +: 32] !== one_to_16[15-j]) begin
        errors++;
        $display("FAIL single_sorted lane %0d: got %h expected %h", j, y[32*j +: 32],
                 one_to_16[15-j]);
      end
    end
    tick();
    exp2[0] = 32'h42C80000;
    for (int j = 1; j <= 8; j++) exp2[j] = one_to_16[16-j];  // 16.0 .. 9.0
    exp2[9] = 32'h41080000;
    for (int j = 10; j < 16; j++) exp2[j] = one_to_16[17-j];  // 8.0 .. 3.0
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (y[32*j +: 32] !== exp2[j]) begin
        errors++;
        $display("FAIL second_vector lane %0d: got %h expected %h", j, y[32*j +: 32], exp2[j]);
      end
    end
    // Vectors presented with i_valid low must never enter the accumulator.
    for (int j = 0; j < 16; j++) x[32*j +: 32] = 32'h7149F2CA;  // 1e30
    for (int c = 0; c < 13; c++) tick();
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (y[32*j +: 32] !== exp2[j]) begin
        errors++;
        $display("FAIL invalid_ignored lane %0d: got %h expected %h", j, y[32*j +: 32],
                 exp2[j]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] exp3 [16];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 16; j++) x[32*j +: 32] = 32'hC0000000;  // -2.0
    x[31:0]    = 32'h00000000;
    x[63:32]   = 32'h80000000;
    x[95:64]   = 32'hBF800000;
    x[127:96]  = NINF;
    x[159:128] = 32'h7F800000;
    x[191:160] = 32'h00000001;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < LAT; c++) tick();
    exp3[0] = 32'h7F800000; exp3[1] = 32'h00000001; exp3[2] = 32'h00000000;
    exp3[3] = 32'h80000000; exp3[4] = 32'hBF800000;
    for (int j = 5; j < 15; j++) exp3[j] = 32'hC0000000;
    exp3[15] = NINF;
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (y[32*j +: 32] !== exp3[j]) begin
        errors++;
        $display("FAIL specials lane %0d: got %h expected %h", j, y[32*j +: 32], exp3[j]);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    i_valid = 1'b1;
    for (int v = 0; v < 10; v++) begin
      x = rand_vec();
      tick();
    end
    rst = 1'b1;
    x = rand_vec();
    tick();
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (y[32*j +: 32] !== NINF) begin
        errors++;
        $display("FAIL midstream_reset lane %0d: got %h expected %h", j, y[32*j +: 32], NINF);
      end
    end
    for (int v = 0; v < 10; v++) begin
      x = rand_vec();
      tick();
    end
    i_valid = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      for (int j = 0; j < 16; j++) begin
        checks++;
        if (y[32*j +: 32] !== pool[j]) begin
          errors++;
          $display("FAIL b2b_drain cyc %0d lane %0d: got %h expected %h", c, j,
                   y[32*j +: 32], pool[j]);
        end
      end
    end
  endtask

  task automatic test_random_gaps();
    for (int c = 0; c < 60; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      rst     = (c == 30);
      x       = rand_vec();
      tick();
      for (int j = 0; j < 16; j++) begin
        checks++;
        if (y[32*j +: 32] !== pool[j]) begin
          errors++;
          $display("FAIL random_gaps cyc %0d lane %0d: got %h expected %h", c, j,
                   y[32*j +: 32], pool[j]);
        end
      end
    end
    rst = 1'b0;
    i_valid = 1'b0;
    for (int c = 0; c < LAT + 1; c++) begin
      tick();
      for (int j = 0; j < 16; j++) begin
        checks++;
        if (y[32*j +: 32] !== pool[j]) begin
          errors++;
          $display("FAIL random_drain cyc %0d lane %0d: got %h expected %h", c, j,
                   y[32*j +: 32], pool[j]);
        end
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    x       = '0;
    test_reset();
    test_single_and_second();
    test_specials();
    test_back_to_back_reset();
    test_random_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/topk_top.md
TOPK_TOP -- requirements
Module: topk_top

Interface
REQ-001 Parameter DATA_WIDTH, default 32, element width; elements are IEEE-754 single-precision floats.
REQ-002 Parameter LOG_INPUT_NUM, default 4, log2 of lane count N = 2**LOG_INPUT_NUM (16), which is also K, the number of results retained.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  1  high means x carries a new vector this cycle.
REQ-006 x  input  DATA_WIDTH*N  packed input vector; lane j occupies bits [DATA_WIDTH*(j+1)-1 -: DATA_WIDTH].
REQ-007 y  output  DATA_WIDTH*N  running top-N of all accepted elements since reset, same lane packing, lane 0 = largest.

Function
REQ-008 The block shall sample x on every rising edge where i_valid=1 and rst=0; vectors with i_valid=0 are ignored entirely.
REQ-009 Ordering shall use a total-order key per element: sign=0 -> bits XOR 0x80000000; sign=1 -> bitwise NOT of bits; larger key = larger value.
REQ-010 Under REQ-009: -0.0 < +0.0; +NaN ranks above +inf; -NaN ranks below -inf; no special NaN handling beyond this.
REQ-011 Stage A shall sort each accepted vector descending with a bitonic network of S = LOG_INPUT_NUM*(LOG_INPUT_NUM+1)/2 compare-exchange stages (10 for N=16), one register stage per network stage, a valid bit travelling with the data.
REQ-012 Stage B shall hold an N-entry accumulator T, always sorted descending.
REQ-013 When a sorted vector U leaves stage A valid, the edge that samples it shall update T <= descending sort of top N of (T union U): lane-wise max(T[i], U[N-1-i]) yields a bitonic top-N, then a LOG_INPUT_NUM-level bitonic half-cleaner merge, combinational, registered into T.
REQ-014 Duplicates shall be retained as separate entries (multiset semantics); equal keys may appear in any order among themselves only if bit patterns are identical.
REQ-015 y shall be driven directly from T (registered output, no combinational path from x).
REQ-016 Latency: a vector sampled at edge k shall be reflected in y after edge k+S+1 (11 edges for N=16); throughput one vector per cycle, back-to-back vectors supported with no stall.
REQ-017 A stage A slot with valid=0 reaching stage B shall leave T unchanged.

Reset
REQ-018 While rst=1 at a rising edge, every stage A valid bit shall clear and every T entry shall load 0xFF800000 (-inf), so y reads -inf on all lanes after that edge.
REQ-019 rst asserted mid-stream shall discard all in-flight vectors; no vector sampled at or before the reset edge shall ever affect T.
REQ-020 rst shall have priority over i_valid on the same edge; that vector is not accepted.

Verification
REQ-021 Reset then idle: after reset edge with i_valid=0 for 20 cycles -> y lanes 0..15 all 0xFF800000.
REQ-022 Single vector of 1.0..16.0 in shuffled lanes -> exactly 11 edges later y lane0=16.0 ... lane15=1.0; one edge earlier y still all -inf.
REQ-023 Second vector {100.0, -5.0, 8.5, 0.5, rest -100.0} one cycle after REQ-022 -> y = 100.0,16,15,...,9,8.5,8,7,6,5,4,3 (lane15=3.0).
REQ-024 Vector with i_valid=0 containing all 1e30 -> y unchanged.
REQ-025 Vector {+0.0, -0.0, -1.0, -inf, +inf, 1e-45, rest -2.0} after reset -> y = +inf, 1e-45, +0.0, -0.0, -1.0, -2.0 x10, -inf.
REQ-026 20 random vectors back-to-back, rst pulsed after vector 10 -> final y equals descending top 16 of vectors 11..20 only, checked against a software model using REQ-009 keys.
